// File: rtl/axi_lite_pid_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pid_pkg
// Shared register map, response codes and address decode for the AXI4-Lite
// PID configuration slave.
//   - byte offsets of the fixed registers and of the per-channel blocks
//   - CTRL / STATUS bit positions
//   - decode_addr(): word index -> register kind / channel / coefficient
//   - strobe_mask(): WSTRB -> 32-bit byte mask
// ---------------------------------------------------------------------------
package axi_lite_pid_pkg;

    localparam int unsigned CTRL_OFFSET   = 'h00;
    localparam int unsigned STATUS_OFFSET = 'h04;
    localparam int unsigned ID_OFFSET     = 'h08;
    localparam int unsigned RSVD_OFFSET   = 'h0C;
    localparam int unsigned CH_BASE       = 'h10;
    localparam int unsigned CH_STRIDE     = 'h10;

    localparam logic [31:0] PID_ID = 32'h5049_4432;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_COMMIT_BIT    = 0;
    localparam int CTRL_EN_LSB        = 8;
    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_SAT_LSB     = 8;

    // Coefficient order inside a channel block (+0, +4, +8, +C).
    typedef enum logic [1:0] {
        COEF_KP = 2'd0,
        COEF_KI = 2'd1,
        COEF_KD = 2'd2,
        COEF_SP = 2'd3
    } coef_sel_e;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_STATUS,
        REG_ID,
        REG_RSVD,
        REG_COEF,
        REG_BAD
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e kind;
        logic [2:0] ch;
        coef_sel_e sel;
    } reg_dec_t;

    // Decode a 32-bit word index (byte address >> 2). Comparing word indices
    // rather than shifting back to bytes keeps wide addresses from aliasing.
    function automatic reg_dec_t decode_addr(input logic [31:0] word,
                                             input int unsigned num_ch);
        reg_dec_t d;
        d.kind = REG_BAD;
        d.ch   = '0;
        d.sel  = COEF_KP;
        if (word == CTRL_OFFSET / 4)
            d.kind = REG_CTRL;
        else if (word == STATUS_OFFSET / 4)
            d.kind = REG_STATUS;
        else if (word == ID_OFFSET / 4)
            d.kind = REG_ID;
        else if (word == RSVD_OFFSET / 4)
            d.kind = REG_RSVD;
        else if (word < (CH_BASE + CH_STRIDE * num_ch) / 4) begin
            d.kind = REG_COEF;
            d.ch   = 3'((word - CH_BASE / 4) / (CH_STRIDE / 4));
            d.sel  = coef_sel_e'(word[1:0]);
        end
        return d;
    endfunction

    function automatic logic [31:0] strobe_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++)
            m[8*b +: 8] = {8{strb[b]}};
        return m;
    endfunction

endpackage

// File: rtl/pid_cfg_channel.sv
// ---------------------------------------------------------------------------
// pid_cfg_channel
// Shadow and active KP/KI/KD/SP registers for one PID channel.
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_sel   : write strobe and target coefficient of the shadow bank
//   wdata, wstrb    : AXI write data and byte strobes
//   commit          : copy the whole shadow bank into the active bank
//   shadow_o        : shadow values (read-back path)
//   active_o        : active values driven to the PID datapath
// ---------------------------------------------------------------------------
module pid_cfg_channel
    import axi_lite_pid_pkg::*;
#(
    parameter int COEF_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  coef_sel_e                   wr_sel,
    input  logic [31:0]                 wdata,
    input  logic [3:0]                  wstrb,
    input  logic                        commit,
    output logic [3:0][COEF_WIDTH-1:0]  shadow_o,
    output logic [3:0][COEF_WIDTH-1:0]  active_o
);

    logic [3:0][COEF_WIDTH-1:0] shadow_q;
    logic [3:0][COEF_WIDTH-1:0] active_q;
    logic [31:0] cur_ext;
    logic [31:0] mask;
    logic [31:0] merged;
    logic        unused_merged_bits;

    // Byte-merge in a 32-bit frame; bits at or above COEF_WIDTH are dropped
    // when stored, so they always read back as zero.
    always_comb begin
        cur_ext = '0;
        cur_ext[COEF_WIDTH-1:0] = shadow_q[wr_sel];
        mask   = strobe_mask(wstrb);
        merged = (cur_ext & ~mask) | (wdata & mask);
    end

    assign unused_merged_bits = ^merged;

    always_ff @(posedge clk) begin
        // NOTE: shadow and active banks are plain flops, not RAM, so they
        // take the reset like any other state.
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make a commit on the same edge
            // as a shadow write copy the pre-write shadow value.
            if (wr_en)
                shadow_q[wr_sel] <= merged[COEF_WIDTH-1:0];
            if (commit)
                active_q <= shadow_q;
        end
    end

    assign shadow_o = shadow_q;
    assign active_o = active_q;

endmodule

// File: rtl/axi_lite_pid_cfg.sv
// ---------------------------------------------------------------------------
// axi_lite_pid_cfg
// AXI4-Lite configuration slave for NUM_CH PID loops. Coefficients land in
// shadow registers and move to the active outputs on a commit, which waits
// while hold_i is high. Per-channel saturation is kept in sticky W1C bits.
//   ACLK, ARESET          : clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*       : write address / data / response channels
//   S_AXI_AR*/R*          : read address / data channels
//   kp_o, ki_o, kd_o, sp_o: active coefficients, channel c at [c*CW +: CW]
//   ch_en_o               : active channel enables
//   commit_o              : one-cycle pulse when active values update
//   hold_i                : datapath busy, defers a pending commit
//   sat_i                 : per-channel saturation pulses
// ---------------------------------------------------------------------------
module axi_lite_pid_cfg
    import axi_lite_pid_pkg::*;
#(
    parameter int NUM_CH             = 4,
    parameter int COEF_WIDTH         = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [NUM_CH*COEF_WIDTH-1:0]       kp_o,
    output logic [NUM_CH*COEF_WIDTH-1:0]       ki_o,
    output logic [NUM_CH*COEF_WIDTH-1:0]       kd_o,
    output logic [NUM_CH*COEF_WIDTH-1:0]       sp_o,
    output logic [NUM_CH-1:0]                  ch_en_o,
    output logic                               commit_o,
    input  logic                               hold_i,
    input  logic [NUM_CH-1:0]                  sat_i
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    reg_dec_t wr_dec, rd_dec;
    logic wr_fire, rd_fire, ctrl_wr, commit_wr, commit_fire;
    logic bvalid_q, rvalid_q, pending_q, commit_q;
    logic [1:0] bresp_q, rresp_q;
    logic [31:0] rdata_q, rd_mux;
    logic [COEF_WIDTH-1:0] rd_coef;
    logic [NUM_CH-1:0] en_shadow_q, en_active_q, sticky_q, sat_clr;
    logic [3:0][COEF_WIDTH-1:0] ch_shadow [NUM_CH];
    logic [3:0][COEF_WIDTH-1:0] ch_active [NUM_CH];
    logic unused_addr_bits;

    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_dec = decode_addr(32'(S_AXI_AWADDR[AW-1:2]), NUM_CH);
    assign rd_dec = decode_addr(32'(S_AXI_ARADDR[AW-1:2]), NUM_CH);

    // Ready is a function of the valids; the following cycle has BVALID /
    // RVALID set, so each ready is naturally a single-cycle pulse.
    assign wr_fire = !ARESET && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
    assign rd_fire = !ARESET && S_AXI_ARVALID && !rvalid_q;

    assign ctrl_wr   = wr_fire && (wr_dec.kind == REG_CTRL);
    assign commit_wr = ctrl_wr && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_COMMIT_BIT];
    assign sat_clr   = (wr_fire && (wr_dec.kind == REG_STATUS) && S_AXI_WSTRB[STATUS_SAT_LSB/8])
                     ? S_AXI_WDATA[STATUS_SAT_LSB +: NUM_CH] : '0;
    assign commit_fire = pending_q && !hold_i;

    // Write response channel.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (wr_fire) begin
            bvalid_q <= 1'b1;
            bresp_q  <= (wr_dec.kind == REG_BAD) ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read data channel; the mux samples state before any same-edge write.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
            rresp_q  <= (rd_dec.kind == REG_BAD) ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    // CTRL / STATUS / commit state. A commit write seen while a commit is
    // already pending is absorbed into it.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            en_shadow_q <= '0;
            en_active_q <= '0;
            sticky_q    <= '0;
            pending_q   <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            if (ctrl_wr && S_AXI_WSTRB[CTRL_EN_LSB/8])
                en_shadow_q <= S_AXI_WDATA[CTRL_EN_LSB +: NUM_CH];
            pending_q <= pending_q ? hold_i : commit_wr;
            commit_q  <= commit_fire;
            if (commit_fire)
                en_active_q <= en_shadow_q;
            // Set beats clear when both land on the same edge.
            sticky_q <= (sticky_q & ~sat_clr) | sat_i;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pid_cfg_channel #(
            .COEF_WIDTH (COEF_WIDTH)
        ) u_ch (
            .clk      (ACLK),
            .rst      (ARESET),
            .wr_en    (wr_fire && (wr_dec.kind == REG_COEF) && (wr_dec.ch == 3'(c))),
            .wr_sel   (wr_dec.sel),
            .wdata    (S_AXI_WDATA),
            .wstrb    (S_AXI_WSTRB),
            .commit   (commit_fire),
            .shadow_o (ch_shadow[c]),
            .active_o (ch_active[c])
        );
        assign kp_o[c*COEF_WIDTH +: COEF_WIDTH] = ch_active[c][COEF_KP];
        assign ki_o[c*COEF_WIDTH +: COEF_WIDTH] = ch_active[c][COEF_KI];
        assign kd_o[c*COEF_WIDTH +: COEF_WIDTH] = ch_active[c][COEF_KD];
        assign sp_o[c*COEF_WIDTH +: COEF_WIDTH] = ch_active[c][COEF_SP];
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can infer a latch.
        rd_mux  = '0;
        rd_coef = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (rd_dec.ch == 3'(c))
                rd_coef = ch_shadow[c][rd_dec.sel];
        case (rd_dec.kind)
            REG_CTRL:   rd_mux[CTRL_EN_LSB +: NUM_CH] = en_shadow_q;
            REG_STATUS: begin
                rd_mux[STATUS_PENDING_BIT]        = pending_q;
                rd_mux[STATUS_SAT_LSB +: NUM_CH]  = sticky_q;
            end
            REG_ID:     rd_mux = PID_ID;
            REG_COEF:   rd_mux[COEF_WIDTH-1:0] = rd_coef;
            default:    ;
        endcase
    end

    assign S_AXI_AWREADY = wr_fire;
    assign S_AXI_WREADY  = wr_fire;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = rd_fire;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign ch_en_o       = en_active_q;
    assign commit_o      = commit_q;

endmodule

// File: doc/axi_lite_pid_cfg.md
# axi_lite_pid_cfg

Parametrised AXI4-Lite configuration slave for a bank of `NUM_CH` PID loops. It supersedes the fixed four-register AXI-to-PID interface. Coefficients are written into shadow registers and copied atomically to the active outputs on a commit. The commit is deferred while the PID datapath holds. The block also reports per-channel saturation through sticky, write-1-to-clear status bits.

## Interface
- `NUM_CH`, 4: number of PID channels, 1..8
- `COEF_WIDTH`, 16: width of each coefficient/setpoint field, 1..32
- `C_S_AXI_ADDR_WIDTH`, 8: AXI address width, at least 8
- `C_S_AXI_DATA_WIDTH`, 32: AXI data width, fixed at 32
- `ACLK` in 1: single clock
- `ARESET` in 1: synchronous, active-high reset
- `S_AXI_AWADDR`/`AWVALID`/`AWREADY` in/in/out, `C_S_AXI_ADDR_WIDTH`/1/1: write address channel
- `S_AXI_WDATA`/`WSTRB`/`WVALID`/`WREADY` in/in/in/out, 32/4/1/1: write data channel
- `S_AXI_BRESP`/`BVALID`/`BREADY` out/out/in, 2/1/1: write response channel
- `S_AXI_ARADDR`/`ARVALID`/`ARREADY` in/in/out, `C_S_AXI_ADDR_WIDTH`/1/1: read address channel
- `S_AXI_RDATA`/`RRESP`/`RVALID`/`RREADY` out/out/out/in, 32/2/1/1: read data channel
- `kp_o`, `ki_o`, `kd_o`, `sp_o` out, `NUM_CH*COEF_WIDTH` each: active values; channel c occupies bits `[c*COEF_WIDTH +: COEF_WIDTH]`
- `ch_en_o` out `NUM_CH`: active channel enables
- `commit_o` out 1: one-cycle pulse when the active values update
- `hold_i` in 1: PID datapath mid-computation; defers the commit
- `sat_i` in `NUM_CH`: per-channel saturation pulse

## Operation
- **Register map** (decode uses `addr[C_S_AXI_ADDR_WIDTH-1:2]`):
  - 0x00 CTRL: bit0 COMMIT, write-only, reads 0; bits[8+NUM_CH-1:8] shadow channel enables
  - 0x04 STATUS: bit0 commit_pending (RO); bits[8+NUM_CH-1:8] sticky saturation (W1C)
  - 0x08 ID: RO constant 0x50494432
  - 0x0C: reserved, reads 0, writes ignored, OKAY
  - Channel c at 0x10+0x10·c: +0 KP, +4 KI, +8 KD, +C SP (shadow values)
- **Write accept:** when `AWVALID && WVALID && !BVALID`, assert `AWREADY` and `WREADY` together for exactly one cycle.
- **WSTRB:** per-byte on shadow registers. Bits at or above `COEF_WIDTH` are not stored and read 0.
- **Reads:** return shadow values, not active values.
- **Out-of-map address:** any address ≥ 0x10+0x10·NUM_CH. Write is ignored with BRESP=2'b10 (SLVERR). Read returns RDATA=0 with RRESP=2'b10. All others return OKAY (2'b00).
- **Commit:** a CTRL write with WDATA[0]=1 and WSTRB[0]=1 sets `pending`. On any cycle with `pending && !hold_i`:
  - all shadow values (including enables) copy to active outputs
  - `commit_o` pulses
  - `pending` clears
- **Commit vs. new commit write:** a commit write arriving while pending is already set is absorbed; only one commit results.
- **Saturation:** `sat_i[c]` sets sticky bit c. A W1C write clears it. If set and clear occur in the same cycle, set wins.
- **Reset:** all shadow, active, sticky and pending state is 0. All READY/VALID outputs are 0. BRESP=RRESP=0, RDATA=0, `commit_o`=0.
- **Reset mid-transaction:** any outstanding B/R response is dropped. No response is issued after reset.

## Timing
- **Write:** handshake at edge T. Shadow register and `BVALID` update at T+1. `BVALID` holds until `BREADY`. The earliest next write accept is the cycle after the `BVALID && BREADY` handshake.
- **Read:** `ARREADY` pulses for one cycle when `ARVALID && !RVALID`. `RVALID`/`RDATA` register at the next edge and hold until `RREADY`.
- **Read/write concurrency:** read and write paths are independent. A read accepted in the same cycle as a write to the same address returns the pre-write value.
- **Commit latency:** `pending` is visible at T+1. With `hold_i` low, active outputs and `commit_o` update at T+2. With `hold_i` high, the commit occurs on the first edge after `hold_i` falls.
- **Shadow write vs. commit:** a shadow write landing on the same edge as a commit is not included in that commit.

## Structure
- **Package `axi_lite_pid_pkg`:**
  - register offsets and `CH_STRIDE`
  - `PID_ID` constant
  - `RESP_OKAY`/`RESP_SLVERR`
  - CTRL/STATUS bit positions
- **Sub-module `pid_cfg_channel`:** shadow plus active KP/KI/KD/SP for one channel, with byte-strobed write and commit copy. Instantiated `NUM_CH` times via generate.
- **Top level:** AXI handshakes, decode, CTRL/STATUS/pending logic and read mux.

## Test plan
- **Coefficient load:** write KP/KI/KD/SP of channel 2 to 0x1234/0x0056/0x0078/0x0100 -> read-back is exact; `kp_o` channel 2 stays 0 until commit.
- **Commit with hold:** write CTRL=0x00000F01 with `hold_i`=1 for 10 cycles -> STATUS bit0=1, no `commit_o`. Release hold -> one `commit_o` pulse on the next edge, `ch_en_o`=4'hF, and active values match shadow.
- **Strobes and width:** WSTRB=4'b0010, WDATA=0xAABBCCDD to KP ch0 (previously 0x1111) -> reads 0xCC11. Write 0xFFFFFFFF -> reads 0x0000FFFF.
- **Decode error:** write to 0x50 with NUM_CH=4 -> BRESP=2'b10, no state change. Read of 0x50 -> RDATA=0, RRESP=2'b10. Read of 0x08 -> 0x50494432, OKAY.
- **Sticky saturation:** pulse `sat_i`=4'b0101 -> STATUS=0x00000500. W1C 0x100 in the same cycle as another `sat_i[0]` pulse -> bit 8 stays set.
- **Backpressure and reset:** hold BREADY/RREADY low for 5 cycles -> VALID stays stable and no second write is accepted. Assert ARESET while `BVALID`=1 -> all outputs 0 on the next edge.
